// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: default geometry and FSM state type.
package systolic_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned N_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_skew_delay.sv
// Data plus valid delay line of fixed depth, used to skew one edge lane of the array.
module skew_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_vld  [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        r_data[j] <= '0;
        r_vld[j]  <= 1'b0;
      end
    end else if (i_clr) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        r_data[j] <= '0;
        r_vld[j]  <= 1'b0;
      end
    end else begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_valid;
      for (int unsigned j = 1; j < DEPTH; j++) begin
        r_data[j] <= r_data[j-1];
        r_vld[j]  <= r_vld[j-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds A columns and B rows into an N x N systolic MAC array with per-lane skew,
// per-lane valids and a completion pulse once the last operand has drained.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned K      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic [N*DATA_W-1:0] b_vec,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N*DATA_W-1:0] b_out,
  output logic [N-1:0]        a_valid,
  output logic [N-1:0]        b_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned FW = $clog2(N + 1);

  feeder_state_t r_state;
  logic [CW-1:0] r_beat_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;

  logic                w_accept;
  logic [CW-1:0]       w_beat_next;
  logic [N*DATA_W-1:0] w_a_in;
  logic [N*DATA_W-1:0] w_b_in;

  // A beat presented on an abort cycle is dropped, so abort gates the accept.
  assign w_accept    = (r_state == FEED) && in_valid && !abort;
  assign w_beat_next = r_beat_cnt + CW'(1);
  assign w_a_in      = w_accept ? a_vec : '0;
  assign w_b_in      = w_accept ? b_vec : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= IDLE;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= FEED;
              r_beat_cnt <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          FEED: begin
            if (in_valid) begin
              r_beat_cnt <= w_beat_next;
              if (w_beat_next == CW'(K)) begin
                r_state     <= FLUSH;
                r_flush_cnt <= '0;
                r_in_ready  <= 1'b0;
              end
            end
          end
          FLUSH: begin
            if (r_flush_cnt == FW'(N - 1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_flush_cnt <= r_flush_cnt + FW'(1);
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    skew_delay #(
      .DEPTH (i + 1),
      .WIDTH (DATA_W)
    ) u_a_skew (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (abort),
      .i_data  (w_a_in[i*DATA_W +: DATA_W]),
      .i_valid (w_accept),
      .o_data  (a_out[i*DATA_W +: DATA_W]),
      .o_valid (a_valid[i])
    );

    skew_delay #(
      .DEPTH (i + 1),
      .WIDTH (DATA_W)
    ) u_b_skew (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (abort),
      .i_data  (w_b_in[i*DATA_W +: DATA_W]),
      .i_valid (w_accept),
      .o_data  (b_out[i*DATA_W +: DATA_W]),
      .o_valid (b_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed jobs plus random jobs against a timeline model
// that logs accepted beats by edge number and derives each lane's view from that log.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] a_vec = '0;
  logic [VW-1:0] b_vec = '0;
  logic          in_ready;
  logic [VW-1:0] a_out;
  logic [VW-1:0] b_out;
  logic [N-1:0]  a_valid;
  logic [N-1:0]  b_valid;
  logic          busy;
  logic          done;

  systolic_feeder #(
    .N      (N),
    .DATA_W (DW),
    .K      (K)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .a_out    (a_out),
    .b_out    (b_out),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: job status plus a log of accepted beats keyed by edge number.
  bit            m_active = 1'b0;
  bit            m_feed   = 1'b0;
  int            m_nacc   = 0;
  int            m_done_edge = -10;
  int            m_kill   = 0;
  bit            hv [int];
  logic [VW-1:0] ha [int];
  logic [VW-1:0] hb [int];

  int done_seen = 0;
  int done_at   = -1;
  int acc_seen  = 0;
  int s_edge    = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int base, input int sgn);
    logic [VW-1:0] v;
    int x;
    v = '0;
    for (int i = 0; i < N; i++) begin
      x = sgn * (base + i + 1);
      v[i*DW +: DW] = x[DW-1:0];
    end
    return v;
  endfunction

  task automatic tick();
    int            c;
    logic [VW-1:0] ea, eb, ta, tb;
    logic [N-1:0]  ev;
    c = cyc + 1;
    if (in_ready === 1'b1 && in_valid && !abort) acc_seen++;
    if (abort) begin
      m_active = 1'b0;
      m_feed   = 1'b0;
      m_kill   = c;
    end else if (m_active && !m_feed && c == m_done_edge + 1) begin
      m_active = 1'b0;
    end else if (!m_active && start) begin
      m_active = 1'b1;
      m_feed   = 1'b1;
      m_nacc   = 0;
    end else if (m_feed && in_valid) begin
      hv[c] = 1'b1;
      ha[c] = a_vec;
      hb[c] = b_vec;
      m_nacc++;
      if (m_nacc == K) begin
        m_feed      = 1'b0;
        m_done_edge = c + N;
      end
    end
    @(posedge clk);
    cyc = c;
    #1;
    ea = '0; eb = '0; ev = '0;
    for (int i = 0; i < N; i++) begin
      int e;
      e = c - i;
      if (hv.exists(e) && e > m_kill) begin
        ta = ha[e];
        tb = hb[e];
        ev[i] = 1'b1;
        ea[i*DW +: DW] = ta[i*DW +: DW];
        eb[i*DW +: DW] = tb[i*DW +: DW];
      end
    end
    chk("in_ready", VW'(in_ready), VW'(m_feed));
    chk("busy",     VW'(busy),     VW'(m_active));
    chk("done",     VW'(done),     VW'(m_active && !m_feed && c == m_done_edge));
    chk("a_valid",  VW'(a_valid),  VW'(ev));
    chk("b_valid",  VW'(b_valid),  VW'(ev));
    chk("a_out",    a_out, ea);
    chk("b_out",    b_out, eb);
    if (done === 1'b1) begin
      done_seen++;
      done_at = c;
    end
  endtask

  task automatic idle(input int n);
    start = 0; abort = 0; in_valid = 0; a_vec = '0; b_vec = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input logic [VW-1:0] a, input logic [VW-1:0] b);
    in_valid = 1; a_vec = a; b_vec = b;
    tick();
    in_valid = 0; a_vec = '0; b_vec = '0;
  endtask

  task automatic begin_job();
    done_seen = 0;
    done_at   = -1;
    s_edge    = cyc + 1;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a_out"},    a_out, '0);
    chk({tag, "_b_out"},    b_out, '0);
    chk({tag, "_a_valid"},  VW'(a_valid), '0);
    chk({tag, "_b_valid"},  VW'(b_valid), '0);
    chk({tag, "_busy"},     VW'(busy), '0);
    chk({tag, "_in_ready"}, VW'(in_ready), '0);
    chk({tag, "_done"},     VW'(done), '0);
  endtask

  initial begin
    #3;
    check_zero_outputs("rst_init");
    @(negedge clk);
    reset = 1;
    idle(2);

    // Back-to-back job
    begin_job();
    for (int k = 0; k < K; k++) beat(pk(10*k, 1), pk(10*k, -1));
    idle(8);
    chk("b2b_done_count", VW'(done_seen), VW'(1));
    chk("b2b_done_delay", VW'(done_at - s_edge), VW'(K + N));

    // Two bubbles between beats 1 and 2
    begin_job();
    beat(pk(0, 1), pk(0, -1));
    idle(2);
    beat(pk(10, 1), pk(10, -1));
    beat(pk(20, 1), pk(20, -1));
    idle(8);
    chk("gap_done_count", VW'(done_seen), VW'(1));
    chk("gap_done_delay", VW'(done_at - s_edge), VW'(K + N + 2));

    // Abort the cycle after the second accept, with a beat on the abort cycle
    begin_job();
    beat(pk(0, 1), pk(0, -1));
    beat(pk(10, 1), pk(10, -1));
    abort = 1;
    beat(pk(20, 1), pk(20, -1));
    abort = 0;
    idle(8);
    chk("abort_no_done", VW'(done_seen), VW'(0));
    begin_job();
    for (int k = 0; k < K; k++) beat(pk(10*k + 40, 1), pk(10*k + 40, -1));
    idle(8);
    chk("post_abort_done", VW'(done_seen), VW'(1));
    chk("post_abort_delay", VW'(done_at - s_edge), VW'(K + N));

    // start held through FEED and FLUSH, then start+abort in IDLE
    begin_job();
    acc_seen = 0;
    start = 1; in_valid = 1;
    for (int i = 0; i < K + N; i++) begin
      a_vec = pk(i, 1); b_vec = pk(i, -1);
      tick();
    end
    start = 0; in_valid = 0; a_vec = '0; b_vec = '0;
    tick();
    start = 1; abort = 1;
    tick();
    tick();
    idle(3);
    chk("held_accepts", VW'(acc_seen), VW'(K));
    chk("held_done_count", VW'(done_seen), VW'(1));

    // Extreme operands
    begin_job();
    beat({N{8'h80}}, {N{8'h7F}});
    beat({N{8'h7F}}, {N{8'h80}});
    beat({N{8'h80}}, {N{8'h80}});
    idle(8);
    chk("ext_done_count", VW'(done_seen), VW'(1));

    // Random jobs with random bubbles, data and occasional aborts
    for (int j = 0; j < 6; j++) begin
      begin_job();
      for (int t = 0; t < 24; t++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        abort    = ($urandom_range(0, 29) == 0);
        a_vec    = VW'($urandom());
        b_vec    = VW'($urandom());
        tick();
      end
      idle(2);
    end

    // Asynchronous reset in the middle of FEED
    begin_job();
    beat(pk(0, 1), pk(0, -1));
    in_valid = 1; a_vec = pk(10, 1); b_vec = pk(10, -1);
    #2;
    reset = 0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    reset = 1;
    m_active = 1'b0; m_feed = 1'b0; m_kill = cyc; m_done_edge = -10;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
